shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Command sequencer for the 8-bit op-coded shift register. Accepts one command
//  (mode, seed, shift count) over a valid/ready handshake. Drives the shifter's
//  op/din for LOAD then N shift cycles, captures the result and returns it over
//  a valid/ready response channel. Sits between a CPU/bus-side requester and the
//  shifter; it is the only driver of the shifter's op/din.
// PARAMETERS
//  DW  8  data width; must match shifter width
//  CW  4  shift-count width; max shifts per command = 2**CW-1
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   high only in IDLE; accept on valid&&ready
//  cmd_mode   in   3   shifter op to repeat (010..111); 000/001 = load only
//  cmd_data   in   DW  seed value loaded into shifter
//  cmd_cnt    in   CW  number of shift cycles
//  ser_in     in   1   serial bit for mode 101, sampled every SHIFT cycle
//  sh_op      out  3   to shifter op
//  sh_din     out  DW  to shifter din
//  sh_dout    in   DW  shifter registered output
//  rsp_valid  out  1   result valid; held until rsp_ready
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  DW  captured shifter value
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Op codes: 000 hold, 001 load, 010 lsr, 011 lsl, 100 asr, 101 serial-in
//   right (din[0] into MSB), 110 ror, 111 rol.
//  Reset (async): state=IDLE, sh_op=000, sh_din=0, rsp_valid=0, rsp_data=0,
//   busy=0, internal mode/cnt/remaining = 0. Reset mid-command drops the command;
//   no response is ever issued for it.
//  FSM: IDLE -> LOAD -> SHIFT -> CAPT -> RESP -> IDLE.
//   IDLE : sh_op=000. On accept latch mode, data, cnt -> LOAD.
//   LOAD : one cycle, sh_op=001, sh_din=latched data. Next: SHIFT if cnt!=0 and
//          mode in 010..111, else CAPT.
//   SHIFT: sh_op=mode for exactly cnt cycles (down-counter rem, loaded with cnt,
//          decremented per cycle; leave when rem==1). sh_din={0..,ser_in}
//          for mode 101, else 0.
//   CAPT : one cycle, sh_op=000; rsp_data <= sh_dout at end of cycle -> RESP.
//   RESP : sh_op=000, rsp_valid=1, rsp_data stable; on rsp_ready -> IDLE.
//  Latency: accept edge E0; rsp_valid rises after edge E0+cnt+2 (cnt=0 or
//   load-only mode: E0+2). Throughput: one command per cnt+4 cycles minimum.
//  No back-to-back accept: cmd_ready=0 in the RESP->IDLE transition cycle;
//   earliest next accept is the cycle after rsp handshake.
//  cmd_mode/cmd_data/cmd_cnt/ser_in ignored outside their sampling states;
//   cmd inputs may change freely after accept.
//  cnt = 2**CW-1 is legal; rem never wraps (only decremented while >=1).
//  sh_op/sh_din are registered outputs (no combinational path from cmd_*).
// CONFIGURATION
//  SHIFT_SEQ_ABORT_EN defined: adds input `abort` (1b) and output `rsp_abort`
//   (1b). abort high in LOAD or SHIFT -> next state CAPT immediately (current
//   cycle's sh_op still issued); rsp_abort=1 with that response, cleared on
//   rsp handshake. abort ignored in IDLE/CAPT/RESP.
//  Not defined: ports absent, rsp_abort behaviour absent, FSM as above.
// TESTING
//  1 load-only: mode=001 data=8'hA5 cnt=3 -> sh_op 001 one cycle, no shifts,
//    rsp_valid after E0+2, rsp_data=8'hA5.
//  2 lsl x3: mode=011 data=8'h81 cnt=3 -> exactly 3 cycles sh_op=011,
//    rsp_data=8'h08 at E0+5; asr x2 on 8'h80 -> 8'hE0.
//  3 serial-in: mode=101 data=8'h00 cnt=4, ser_in=1,0,1,1 per SHIFT cycle
//    -> rsp_data=8'hD0; ror x8 on 8'h3C -> 8'h3C (full wrap).
//  4 backpressure: hold rsp_ready=0 10 cycles -> rsp_valid/rsp_data stable,
//    cmd_ready=0, sh_op=000; cmd_valid during RESP not accepted.
//  5 async reset mid-SHIFT (rol cnt=15, reset at 5th shift) -> all outputs
//    zero immediately, no rsp_valid after release; next cmd completes normally.
//  6 (ABORT_EN) rol cnt=10 on 8'h01, abort at 3rd SHIFT cycle -> rsp_data=8'h08,
//    rsp_abort=1.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer for the 8-bit op-coded shift register.
// Takes one command (mode, seed, count), drives LOAD then N shift ops into the
// shifter, captures the result and returns it on a valid/ready response.
// Optional abort support is compiled in when SHIFT_SEQ_ABORT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | shifter op 001 with the seed on din, one cycle
// SHIFT | shifter op = mode, for cnt cycles (down-counter rem)
// CAPT  | shifter idle, result captured into rsp_data at end of cycle
// RESP  | rsp_valid held until rsp_ready
module shift_seq_ctrl #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_mode,
  input  logic [DW-1:0] cmd_data,
  input  logic [CW-1:0] cmd_cnt,
  input  logic          ser_in,
  output logic [2:0]    sh_op,
  output logic [DW-1:0] sh_din,
  input  logic [DW-1:0] sh_dout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic          abort,
  output logic          rsp_abort
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPT, RESP} state_t;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_SERIAL = 3'b101;

  state_t        state, state_nxt;
  logic [2:0]    mode;
  logic [CW-1:0] rem;
  logic [2:0]    op_nxt;
  logic [DW-1:0] din_nxt;
  logic [DW-1:0] ser_din;
  logic          accept;
  logic          shifting_mode;
  logic          abort_req;

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = cmd_valid && cmd_ready;
  // modes 000/001 never shift, whatever the count says
  assign shifting_mode = (mode[2:1] != 2'b00);
  // ser_in is registered into din at the edge that starts each shift cycle
  assign ser_din       = (mode == OP_SERIAL) ? {{(DW-1){1'b0}}, ser_in} : '0;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort && ((state == LOAD) || (state == SHIFT));
`else
  assign abort_req = 1'b0;
`endif

  // next state plus the shifter drive for the cycle after this edge
  always_comb begin
    state_nxt = state;
    op_nxt    = OP_HOLD;
    din_nxt   = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = LOAD;
          op_nxt    = OP_LOAD;
          din_nxt   = cmd_data;
        end
      end
      LOAD: begin
        if (!abort_req && (rem != '0) && shifting_mode) begin
          state_nxt = SHIFT;
          op_nxt    = mode;
          din_nxt   = ser_din;
        end else begin
          state_nxt = CAPT;
        end
      end
      SHIFT: begin
        if (abort_req || (rem <= CW'(1))) begin
          state_nxt = CAPT;
        end else begin
          op_nxt  = mode;
          din_nxt = ser_din;
        end
      end
      CAPT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // command latch and shift down-counter (stops at zero, never wraps)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= '0;
      rem  <= '0;
    end else if (accept) begin
      mode <= cmd_mode;
      rem  <= cmd_cnt;
    end else if ((state == SHIFT) && (rem != '0)) begin
      rem <= rem - CW'(1);
    end
  end

  // registered shifter drive, no combinational path from cmd_*
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_op  <= OP_HOLD;
      sh_din <= '0;
    end else begin
      sh_op  <= op_nxt;
      sh_din <= din_nxt;
    end
  end

  // result capture and hold until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (state == CAPT) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sh_dout;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_SEQ_ABORT_EN
  logic abort_seen;

  // remember an abort for this command and flag it with the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_seen <= 1'b0;
      rsp_abort  <= 1'b0;
    end else begin
      if (accept)         abort_seen <= 1'b0;
      else if (abort_req) abort_seen <= 1'b1;
      if (state == CAPT)                     rsp_abort <= abort_seen;
      else if ((state == RESP) && rsp_ready) rsp_abort <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: shifter model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_mode = '0;
  logic [7:0] cmd_data = '0;
  logic [3:0] cmd_cnt = '0;
  logic       ser_in = 1'b0;
  logic [2:0] sh_op;
  logic [7:0] sh_din;
  logic [7:0] sh_dout;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;
`ifdef SHIFT_SEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       rsp_abort;
`endif

  int checks = 0;
  int errors = 0;
  bit ser_rand = 1'b0;

  shift_seq_ctrl #(.DW(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .ser_in(ser_in),
    .sh_op(sh_op), .sh_din(sh_din), .sh_dout(sh_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
`ifdef SHIFT_SEQ_ABORT_EN
    , .abort(abort), .rsp_abort(rsp_abort)
`endif
  );

  always #5 clk = ~clk;

  // the shifter this block drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_dout <= '0;
    else begin
      case (sh_op)
        3'b001:  sh_dout <= sh_din;
        3'b010:  sh_dout <= sh_dout >> 1;
        3'b011:  sh_dout <= sh_dout << 1;
        3'b100:  sh_dout <= {sh_dout[7], sh_dout[7:1]};
        3'b101:  sh_dout <= {sh_din[0], sh_dout[7:1]};
        3'b110:  sh_dout <= {sh_dout[0], sh_dout[7:1]};
        3'b111:  sh_dout <= {sh_dout[6:0], sh_dout[7]};
        default: sh_dout <= sh_dout;
      endcase
    end
  end

  // closed-form result of n repetitions of an op on a seed
  function automatic logic [7:0] model_result(logic [2:0] m, logic [7:0] seed,
                                              int n, logic [15:0] bits);
    logic [15:0] d;
    logic [7:0]  v;
    d = {seed, seed};
    v = seed;
    case (m)
      3'd2: v = seed >> n;
      3'd3: v = 8'(seed << n);
      3'd4: v = 8'($signed(seed) >>> n);
      3'd5: for (int i = 0; i < n; i++) v = {bits[i], v[7:1]};
      3'd6: begin d = d >> (n % 8); v = d[7:0]; end
      3'd7: begin d = d << (n % 8); v = d[15:8]; end
      default: v = seed;
    endcase
    return v;
  endfunction

  // reference model: m_k = edges since the accept edge of the live command
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_n = 0;
  logic [2:0]  m_mode = '0;
  logic [7:0]  m_seed = '0;
  logic [15:0] m_bits = '0;
  logic [7:0]  m_last = '0;
  bit          m_abt = 1'b0;
  bit          m_last_abt = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_k = 0; m_n = 0; m_last = '0; m_abt = 1'b0; m_last_abt = 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1'b1; m_k = 0; m_mode = cmd_mode; m_seed = cmd_data;
        m_n = (cmd_mode >= 3'd2) ? int'(cmd_cnt) : 0;
        m_bits = '0; m_abt = 1'b0;
      end
    end else if (m_k >= m_n + 2) begin
      if (rsp_ready) begin m_busy = 1'b0; m_last_abt = 1'b0; end
    end else begin
`ifdef SHIFT_SEQ_ABORT_EN
      if (abort && m_k <= m_n) begin m_n = m_k; m_abt = 1'b1; end
`endif
      m_k++;
      if (m_k <= m_n) m_bits[m_k-1] = ser_in;
      if (m_k == m_n + 2) begin
        m_last = model_result(m_mode, m_seed, m_n, m_bits);
        m_last_abt = m_abt;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [2:0] e_op;
    logic [7:0] e_din;
    logic       e_valid;
    e_op = 3'd0; e_din = 8'd0; e_valid = 1'b0;
    if (m_busy) begin
      if (m_k == 0) begin
        e_op = 3'd1; e_din = m_seed;
      end else if (m_k <= m_n) begin
        e_op = m_mode;
        e_din = (m_mode == 3'd5) ? {7'd0, m_bits[m_k-1]} : 8'd0;
      end else if (m_k >= m_n + 2) begin
        e_valid = 1'b1;
      end
    end
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("sh_op", sh_op, e_op);
    chk("sh_din", sh_din, e_din);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("rsp_data", rsp_data, m_last);
`ifdef SHIFT_SEQ_ABORT_EN
    chk("rsp_abort", rsp_abort, m_last_abt);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    if (ser_rand) ser_in = 1'($urandom);
  endtask

  task automatic run_cmd(string name, logic [2:0] m, logic [7:0] d, logic [3:0] c,
                         logic [15:0] ser_pat, logic [7:0] exp_data, int exp_lat,
                         bit do_ack);
    int lat;
    bit seen;
    cmd_valid = 1'b1; cmd_mode = m; cmd_data = d; cmd_cnt = c; rsp_ready = 1'b0;
    tick();
    chk({name, "_accept"}, busy, 1);
    cmd_valid = 1'b0;
    cmd_mode = 3'($urandom); cmd_data = 8'($urandom); cmd_cnt = 4'($urandom);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        ser_in = ser_pat[lat % 16];
        tick();
        lat++;
      end
    end
    chk({name, "_timeout"}, seen, 1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_data"}, rsp_data, exp_data);
    if (do_ack) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({name, "_ack"}, rsp_valid, 0);
      tick();
    end
  endtask

  initial begin
    bit seen;
    #2;
    chk("reset_op", sh_op, 0);
    chk("reset_din", sh_din, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", cmd_ready, 1);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    run_cmd("load_only", 3'b001, 8'hA5, 4'd3, 16'h0, 8'hA5, 2, 1'b1);
    run_cmd("lsl3", 3'b011, 8'h81, 4'd3, 16'h0, 8'h08, 5, 1'b1);
    run_cmd("asr2", 3'b100, 8'h80, 4'd2, 16'h0, 8'hE0, 4, 1'b1);
    run_cmd("serial4", 3'b101, 8'h00, 4'd4, 16'b1101, 8'hD0, 6, 1'b1);
    run_cmd("ror8", 3'b110, 8'h3C, 4'd8, 16'h0, 8'h3C, 10, 1'b1);
    run_cmd("lsr15", 3'b010, 8'hFF, 4'd15, 16'h0, 8'h00, 17, 1'b1);
    run_cmd("lsl0", 3'b011, 8'h5A, 4'd0, 16'h0, 8'h5A, 2, 1'b1);

    // backpressure: response held, commands refused
    run_cmd("bp", 3'b111, 8'h81, 4'd1, 16'h0, 8'h03, 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h03);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_op", sh_op, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_no_accept", busy, 0);
    chk("bp_idle_ready", cmd_ready, 1);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    tick();

    // async reset in the middle of the 5th shift
    cmd_valid = 1'b1; cmd_mode = 3'b111; cmd_data = 8'h01; cmd_cnt = 4'd15;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    chk("rst_pre_op", sh_op, 3'b111);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_op", sh_op, 0);
    chk("rst_din", sh_din, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    tick(); tick();
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_no_rsp", seen, 0);
    run_cmd("post_rst", 3'b010, 8'hF0, 4'd4, 16'h0, 8'h0F, 6, 1'b1);

`ifdef SHIFT_SEQ_ABORT_EN
    begin
      int lat;
      cmd_valid = 1'b1; cmd_mode = 3'b111; cmd_data = 8'h01; cmd_cnt = 4'd10;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      seen = 1'b0; lat = 0;
      while (!seen && lat < 40) begin
        if (rsp_valid) seen = 1'b1;
        else begin tick(); lat++; end
      end
      chk("abort_timeout", seen, 1);
      chk("abort_data", rsp_data, 8'h08);
      chk("abort_flag", rsp_abort, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("abort_flag_clr", rsp_abort, 0);
      tick();
    end
`endif

    // randomized traffic against the model
    ser_rand = 1'b1;
    repeat (3000) begin
      cmd_valid = (($urandom % 4) == 0);
      cmd_mode  = 3'($urandom);
      cmd_data  = 8'($urandom);
      cmd_cnt   = 4'($urandom);
      rsp_ready = (($urandom % 3) != 0);
`ifdef SHIFT_SEQ_ABORT_EN
      abort     = (($urandom % 16) == 0);
`endif
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
